// File: rtl/buzzer_scheduler.sv
// buzzer_scheduler: time-shares the buzzer/LED note path between the free-play,
// auto-play and learn-mode sources. A mode FSM grants one source at a time and
// inserts a silent guard gap on every mode switch.
// Build option: define BUZZER_SCHED_GAP_EN to enable the GAP state and gap_cnt.
// Without it, a switch commits on the edge after sel_q changes, busy is tied 0,
// and the output still goes through one silent cycle.
module buzzer_scheduler #(
  parameter int GAP_CYCLES = 1000000,
  parameter int NOTE_W     = 4,
  parameter int OCT_W      = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        mode_sel,
  input  logic [NOTE_W-1:0] free_note,
  input  logic [OCT_W-1:0]  free_oct,
  input  logic [NOTE_W-1:0] auto_note,
  input  logic [OCT_W-1:0]  auto_oct,
  input  logic [NOTE_W-1:0] learn_note,
  input  logic [OCT_W-1:0]  learn_oct,
  output logic              auto_run,
  output logic              learn_run,
  output logic [NOTE_W-1:0] note_out,
  output logic [OCT_W-1:0]  octave_out,
  output logic [1:0]        mode_out,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GAP    = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  localparam logic [1:0] M_IDLE  = 2'b00;
  localparam logic [1:0] M_FREE  = 2'b01;
  localparam logic [1:0] M_AUTO  = 2'b10;
  localparam logic [1:0] M_LEARN = 2'b11;

  localparam logic [NOTE_W-1:0] NOTE_END = '1;

  state_t            state;
  logic [1:0]        sel_q;
  logic [1:0]        cur_mode;
  logic [NOTE_W-1:0] src_note;
  logic [OCT_W-1:0]  src_oct;
  logic [NOTE_W-1:0] mux_note;

  // Single synchronising register for the level-type mode request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sel_q <= M_IDLE;
    else        sel_q <= mode_sel;
  end

  // Pick the source belonging to the committed mode; idle selects nothing.
  always_comb begin
    src_note = '0;
    src_oct  = '0;
    case (cur_mode)
      M_FREE: begin
        src_note = free_note;
        src_oct  = free_oct;
      end
      M_AUTO: begin
        src_note = auto_note;
        src_oct  = auto_oct;
      end
      M_LEARN: begin
        src_note = learn_note;
        src_oct  = learn_oct;
      end
      default: begin
        src_note = '0;
        src_oct  = '0;
      end
    endcase
  end

  // The end-of-song marker must never reach the buzzer as a tone.
  assign mux_note = (src_note == NOTE_END) ? '0 : src_note;

`ifdef BUZZER_SCHED_GAP_EN

  localparam logic [23:0] GAP_LOAD = 24'(GAP_CYCLES - 1);

  logic [1:0]  pending;
  logic [23:0] gap_cnt;
  logic [1:0]  target;

  // Outside a gap the request is compared with the committed mode,
  // inside a gap with the mode we are currently switching to.
  assign target = (state == ST_GAP) ? pending : cur_mode;

  // Mode FSM with registered outputs: any new request (re)starts a full silent
  // gap; the gap only counts down while the request stays put.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      cur_mode   <= M_IDLE;
      pending    <= M_IDLE;
      gap_cnt    <= '0;
      mode_out   <= M_IDLE;
      note_out   <= '0;
      octave_out <= '0;
      busy       <= 1'b0;
      auto_run   <= 1'b0;
      learn_run  <= 1'b0;
    end else if (sel_q != target) begin
      pending    <= sel_q;
      gap_cnt    <= GAP_LOAD;
      state      <= ST_GAP;
      busy       <= 1'b1;
      note_out   <= '0;
      octave_out <= '0;
      auto_run   <= 1'b0;
      learn_run  <= 1'b0;
    end else begin
      case (state)
        ST_GAP: begin
          if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - 24'd1;
          end else begin
            // Commit: the new source is shown from the following edge on.
            cur_mode  <= pending;
            mode_out  <= pending;
            state     <= (pending == M_IDLE) ? ST_IDLE : ST_ACTIVE;
            busy      <= 1'b0;
            auto_run  <= (pending == M_AUTO);
            learn_run <= (pending == M_LEARN);
          end
        end
        ST_ACTIVE: begin
          note_out   <= mux_note;
          octave_out <= src_oct;
        end
        default: begin
          note_out   <= '0;
          octave_out <= '0;
        end
      endcase
    end
  end

`else

  // A zero or oversized guard length is meaningless; this scope flags it.
  if (GAP_CYCLES < 1 || GAP_CYCLES > 16777215) begin : g_gap_cycles_illegal
  end

  assign busy = 1'b0;

  // Mode FSM without guard gap: commit on the first edge that sees a new
  // request, emitting one silent cycle before the new source appears.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      cur_mode   <= M_IDLE;
      mode_out   <= M_IDLE;
      note_out   <= '0;
      octave_out <= '0;
      auto_run   <= 1'b0;
      learn_run  <= 1'b0;
    end else if (sel_q != cur_mode) begin
      cur_mode   <= sel_q;
      mode_out   <= sel_q;
      state      <= (sel_q == M_IDLE) ? ST_IDLE : ST_ACTIVE;
      note_out   <= '0;
      octave_out <= '0;
      auto_run   <= (sel_q == M_AUTO);
      learn_run  <= (sel_q == M_LEARN);
    end else if (state == ST_ACTIVE) begin
      note_out   <= mux_note;
      octave_out <= src_oct;
    end else begin
      note_out   <= '0;
      octave_out <= '0;
    end
  end

`endif

endmodule

// File: tb/tb_buzzer_scheduler.sv
// Testbench for buzzer_scheduler: directed scenarios plus randomized mode
// requests, sources and asynchronous reset pulses, compared every cycle with a
// timeline model (last request change edge + guard length -> commit edge).
module tb_buzzer_scheduler;

  localparam int GAP = 4;
  localparam int NW  = 4;
  localparam int OW  = 2;
`ifdef BUZZER_SCHED_GAP_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif
  localparam int DLY = GAP_EN ? GAP : 0;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    mode_sel;
  logic [NW-1:0] free_note, auto_note, learn_note;
  logic [OW-1:0] free_oct, auto_oct, learn_oct;
  logic          auto_run, learn_run, busy;
  logic [NW-1:0] note_out;
  logic [OW-1:0] octave_out;
  logic [1:0]    mode_out;

  buzzer_scheduler #(
    .GAP_CYCLES(GAP),
    .NOTE_W    (NW),
    .OCT_W     (OW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mode_sel  (mode_sel),
    .free_note (free_note),
    .free_oct  (free_oct),
    .auto_note (auto_note),
    .auto_oct  (auto_oct),
    .learn_note(learn_note),
    .learn_oct (learn_oct),
    .auto_run  (auto_run),
    .learn_run (learn_run),
    .note_out  (note_out),
    .octave_out(octave_out),
    .mode_out  (mode_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: edge index since reset release, the request value the
  // scheduler last saw change, the edge at which that request commits.
  int         t;
  int         commit_at;
  bit         have_change;
  logic [1:0] prev_ms;
  logic [1:0] last_seen;
  logic [1:0] committed;

  task automatic model_reset();
    t           = 0;
    commit_at   = 0;
    have_change = 1'b0;
    prev_ms     = 2'b00;
    last_seen   = 2'b00;
    committed   = 2'b00;
  endtask

  // Advance one clock edge and compare all outputs with the model.
  task automatic step_and_check();
    logic [1:0]    seen;
    bit            busy_e, commit_edge;
    logic [NW-1:0] n, en, all_ones;
    logic [OW-1:0] o, eo;
    @(posedge clk);
    #1;
    t++;
    seen    = prev_ms;
    prev_ms = mode_sel;
    if (seen != last_seen) begin
      last_seen   = seen;
      have_change = 1'b1;
      commit_at   = t + DLY;
      $display("edge %0d: request %0d seen, commit expected at edge %0d", t, seen, commit_at);
    end
    commit_edge = have_change && (t == commit_at);
    if (commit_edge) committed = last_seen;
    busy_e = GAP_EN && have_change && (t < commit_at);
    case (committed)
      2'b01:   begin n = free_note;  o = free_oct;  end
      2'b10:   begin n = auto_note;  o = auto_oct;  end
      2'b11:   begin n = learn_note; o = learn_oct; end
      default: begin n = '0;         o = '0;        end
    endcase
    all_ones = '1;
    if (committed != 2'b00 && !busy_e && !commit_edge) begin
      en = (n == all_ones) ? '0 : n;
      eo = o;
    end else begin
      en = '0;
      eo = '0;
    end
    check("note_out",   32'(note_out),   32'(en));
    check("octave_out", 32'(octave_out), 32'(eo));
    check("mode_out",   32'(mode_out),   32'(committed));
    check("busy",       32'(busy),       32'(busy_e));
    check("auto_run",   32'(auto_run),   32'(!busy_e && committed == 2'b10));
    check("learn_run",  32'(learn_run),  32'(!busy_e && committed == 2'b11));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step_and_check();
  endtask

  // Pull reset low between clock edges; outputs must fall without a clock.
  task automatic async_reset_pulse();
    #2;
    reset = 1'b0;
    #1;
    check("rst_note",   32'(note_out),   32'd0);
    check("rst_oct",    32'(octave_out), 32'd0);
    check("rst_mode",   32'(mode_out),   32'd0);
    check("rst_busy",   32'(busy),       32'd0);
    check("rst_auto",   32'(auto_run),   32'd0);
    check("rst_learn",  32'(learn_run),  32'd0);
    #1;
    reset = 1'b1;
    model_reset();
    $display("async reset pulse applied");
  endtask

  task automatic randomize_sources();
    free_note  = NW'($urandom);
    auto_note  = NW'($urandom);
    learn_note = NW'($urandom);
    free_oct   = OW'($urandom);
    auto_oct   = OW'($urandom);
    learn_oct  = OW'($urandom);
  endtask

  initial begin
    reset    = 1'b0;
    mode_sel = 2'b00;
    randomize_sources();
    free_note = 4'd5;
    model_reset();
    #12;
    check("reset_note",  32'(note_out),  32'd0);
    check("reset_mode",  32'(mode_out),  32'd0);
    check("reset_busy",  32'(busy),      32'd0);
    check("reset_auto",  32'(auto_run),  32'd0);
    check("reset_learn", 32'(learn_run), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Idle with a live free-play note: stays silent.
    steps(6);

    // Idle -> free with note 3 / octave 2.
    mode_sel  = 2'b01;
    free_note = 4'd3;
    free_oct  = 2'd2;
    steps(GAP + 4);

    // Free -> auto, then learn two cycles later (gap restarts).
    mode_sel = 2'b10;
    steps(2);
    mode_sel = 2'b11;
    steps(GAP + 5);

    // Auto mode: end marker goes silent, a normal note passes.
    mode_sel = 2'b10;
    steps(GAP + 4);
    auto_note = 4'hF;
    steps(1);
    auto_note = 4'd6;
    steps(2);

    // Reset mid-note while auto is running.
    async_reset_pulse();
    steps(3);

    // Return to the same mode through a short detour.
    mode_sel = 2'b01;
    steps(GAP + 4);
    mode_sel = 2'b11;
    steps(1);
    mode_sel = 2'b01;
    steps(GAP + 4);

    // Randomized phase.
    for (int i = 0; i < 1500; i++) begin
      randomize_sources();
      if ($urandom_range(0, 9) == 0) mode_sel = 2'($urandom);
      if ($urandom_range(0, 199) == 0) async_reset_pulse();
      step_and_check();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
